change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 169 ++++++++++++++++
 tb/tb_change_dispenser.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin-change dispenser: pays a refund greedily from ten-yuan and one-yuan tubes,
// one coin per PULSE/GAP slot, and reports any unpaid remainder with done.
module change_dispenser #(
    parameter int unsigned PULSE_LEN = 2,
    parameter int unsigned GAP_LEN   = 2,
    parameter int unsigned TEN_INIT  = 8,
    parameter int unsigned ONE_INIT  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] amount,
    input  logic       refill_ten,
    input  logic       refill_one,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [7:0] short_amt,
    output logic       ten_out,
    output logic       one_out,
    output logic [7:0] ten_cnt,
    output logic [7:0] one_cnt
);

    localparam int unsigned W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   remaining_q, remaining_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   ten_cnt_q, ten_cnt_d;
    logic [W-1:0]   one_cnt_q, one_cnt_d;
    logic [W-1:0]   short_amt_q, short_amt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           short_q, short_d;
    logic           ten_out_q, ten_out_d;
    logic           one_out_q, one_out_d;
    logic           take_ten, take_one;

    // Sequencing: coin choice and remaining update happen on the SELECT->PULSE edge.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        short_d     = short_q;
        short_amt_d = short_amt_q;
        ten_out_d   = ten_out_q;
        one_out_d   = one_out_q;
        take_ten    = 1'b0;
        take_one    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    remaining_d = amount;
                    short_d     = 1'b0;
                    short_amt_d = '0;
                    busy_d      = 1'b1;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                cnt_d = '0;
                if (remaining_q >= W'(10) && ten_cnt_q != '0) begin
                    take_ten    = 1'b1;
                    remaining_d = remaining_q - W'(10);
                    ten_out_d   = 1'b1;
                    state_d     = S_PULSE;
                end else if (remaining_q != '0 && one_cnt_q != '0) begin
                    take_one    = 1'b1;
                    remaining_d = remaining_q - W'(1);
                    one_out_d   = 1'b1;
                    state_d     = S_PULSE;
                end else begin
                    done_d      = 1'b1;
                    short_d     = (remaining_q != '0);
                    short_amt_d = remaining_q;
                    state_d     = S_DONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == W'(PULSE_LEN - 1)) begin
                    ten_out_d = 1'b0;
                    one_out_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_GAP;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == W'(GAP_LEN - 1)) begin
                    state_d = S_SELECT;
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Tube counts: saturating refill; refill and eject in the same cycle cancel.
    always_comb begin
        ten_cnt_d = ten_cnt_q;
        one_cnt_d = one_cnt_q;
        unique case ({refill_ten, take_ten})
            2'b10:   if (ten_cnt_q != '1) ten_cnt_d = ten_cnt_q + W'(1);
            2'b01:   ten_cnt_d = ten_cnt_q - W'(1);
            default: ten_cnt_d = ten_cnt_q;
        endcase
        unique case ({refill_one, take_one})
            2'b10:   if (one_cnt_q != '1) one_cnt_d = one_cnt_q + W'(1);
            2'b01:   one_cnt_d = one_cnt_q - W'(1);
            default: one_cnt_d = one_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            cnt_q       <= '0;
            ten_cnt_q   <= W'(TEN_INIT);
            one_cnt_q   <= W'(ONE_INIT);
            short_amt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            short_q     <= 1'b0;
            ten_out_q   <= 1'b0;
            one_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            ten_cnt_q   <= ten_cnt_d;
            one_cnt_q   <= one_cnt_d;
            short_amt_q <= short_amt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            short_q     <= short_d;
            ten_out_q   <= ten_out_d;
            one_out_q   <= one_out_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign short     = short_q;
    assign short_amt = short_amt_q;
    assign ten_out   = ten_out_q;
    assign one_out   = one_out_q;
    assign ten_cnt   = ten_cnt_q;
    assign one_cnt   = one_cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: cycle-exact coin timing, shortfall,
// busy-time requests, refill interaction/saturation and mid-dispense reset.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [7:0] amount;
    logic       refill_ten;
    logic       refill_one;
    logic       busy, done, short, ten_out, one_out;
    logic [7:0] short_amt, ten_cnt, one_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .amount     (amount),
        .refill_ten (refill_ten),
        .refill_one (refill_one),
        .busy       (busy),
        .done       (done),
        .short      (short),
        .short_amt  (short_amt),
        .ten_out    (ten_out),
        .one_out    (one_out),
        .ten_cnt    (ten_cnt),
        .one_cnt    (one_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue a request, then wait (bounded) for done; returns at the negedge of the done cycle.
    task automatic run_req(input logic [7:0] amt, input string tag);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        req    = 1'b1;
        amount = amt;
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, int'(seen), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int ones;
        int dones;
        rst        = 1'b1;
        req        = 1'b0;
        amount     = '0;
        refill_ten = 1'b0;
        refill_one = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_short", int'(short), 0);
        chk("rst_short_amt", int'(short_amt), 0);
        chk("rst_ten_out", int'(ten_out), 0);
        chk("rst_one_out", int'(one_out), 0);
        chk("rst_ten_cnt", int'(ten_cnt), 8);
        chk("rst_one_cnt", int'(one_cnt), 20);
        rst = 1'b0;

        // amount=12: ten at k+2..3, ones at k+7..8 and k+12..13, done k+17
        @(negedge clk);
        req    = 1'b1;
        amount = 8'd12;
        @(posedge clk);
        #1 req = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            @(negedge clk);
            chk($sformatf("a12_ten_out_k%0d", j), int'(ten_out), int'(j == 2 || j == 3));
            chk($sformatf("a12_one_out_k%0d", j), int'(one_out),
                int'(j == 7 || j == 8 || j == 12 || j == 13));
            chk($sformatf("a12_done_k%0d", j), int'(done), int'(j == 17));
            chk($sformatf("a12_busy_k%0d", j), int'(busy), int'(j <= 17));
            if (j == 17) begin
                chk("a12_short", int'(short), 0);
                chk("a12_short_amt", int'(short_amt), 0);
                chk("a12_ten_cnt", int'(ten_cnt), 7);
                chk("a12_one_cnt", int'(one_cnt), 18);
            end
        end

        // amount=0: done at k+2, no pulses
        @(negedge clk);
        req    = 1'b1;
        amount = 8'd0;
        @(posedge clk);
        #1 req = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            chk($sformatf("a0_done_k%0d", j), int'(done), int'(j == 2));
            chk($sformatf("a0_coin_k%0d", j), int'(ten_out | one_out), 0);
        end
        chk("a0_short", int'(short), 0);
        chk("a0_ten_cnt", int'(ten_cnt), 7);
        chk("a0_one_cnt", int'(one_cnt), 18);

        // Drain: 70 empties the ten tube, 15 leaves three one-yuan coins
        run_req(8'd70, "drain70");
        chk("drain70_ten_cnt", int'(ten_cnt), 0);
        chk("drain70_one_cnt", int'(one_cnt), 18);
        run_req(8'd15, "drain15");
        chk("drain15_short", int'(short), 0);
        chk("drain15_one_cnt", int'(one_cnt), 3);

        // amount=25 with ten=0, one=3: three ones, short 22
        ones = 0;
        @(negedge clk);
        req    = 1'b1;
        amount = 8'd25;
        @(posedge clk);
        #1 req = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (ten_out) chk("a25_ten_out_seen", 1, 0);
            if (one_out && j % 5 == 2) ones++;
            if (done) break;
        end
        chk("a25_one_pulses", ones, 3);
        chk("a25_done", int'(done), 1);
        chk("a25_short", int'(short), 1);
        chk("a25_short_amt", int'(short_amt), 22);
        chk("a25_one_cnt", int'(one_cnt), 0);
        @(negedge clk);
        chk("a25_done_clear", int'(done), 0);
        chk("a25_short_amt_held", int'(short_amt), 22);
        chk("a25_busy_clear", int'(busy), 0);

        // req re-pulsed while busy is ignored
        do_reset();
        dones = 0;
        @(negedge clk);
        req    = 1'b1;
        amount = 8'd1;
        @(posedge clk);
        #1 req = 1'b0;
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            if (done) dones++;
            if (j == 3) begin
                req    = 1'b1;
                amount = 8'd10;
            end
            if (j == 5) req = 1'b0;
        end
        chk("busyreq_dones", dones, 1);
        chk("busyreq_ten_cnt", int'(ten_cnt), 8);
        chk("busyreq_one_cnt", int'(one_cnt), 19);

        // refill_one on the one-coin SELECT->PULSE edge nets to zero
        @(negedge clk);
        req    = 1'b1;
        amount = 8'd1;
        @(posedge clk);
        #1 req = 1'b0;
        refill_one = 1'b1;
        @(posedge clk);
        #1 refill_one = 1'b0;
        @(negedge clk);
        chk("coinc_one_out", int'(one_out), 1);
        chk("coinc_one_cnt", int'(one_cnt), 19);
        repeat (6) @(negedge clk);
        chk("coinc_idle_busy", int'(busy), 0);
        refill_one = 1'b1;
        @(negedge clk);
        refill_one = 1'b0;
        chk("refill_one_cnt", int'(one_cnt), 20);

        // Ten refills held for 256 cycles saturate at 255
        refill_ten = 1'b1;
        repeat (3) @(negedge clk);
        chk("refill_ten_3", int'(ten_cnt), 11);
        repeat (253) @(negedge clk);
        refill_ten = 1'b0;
        chk("refill_ten_sat", int'(ten_cnt), 255);

        // Reset during a ten_out pulse aborts immediately
        do_reset();
        @(negedge clk);
        req    = 1'b1;
        amount = 8'd10;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_ten_out_pre", int'(ten_out), 1);
        chk("abort_ten_cnt_pre", int'(ten_cnt), 7);
        #1 rst = 1'b1;
        #1;
        chk("abort_ten_out", int'(ten_out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_ten_cnt", int'(ten_cnt), 8);
        chk("abort_one_cnt", int'(one_cnt), 20);

        // First edge after reset release accepts req
        @(negedge clk);
        rst    = 1'b0;
        req    = 1'b1;
        amount = 8'd0;
        @(posedge clk);
        #1 req = 1'b0;
        chk("post_rst_busy", int'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_done", int'(done), 1);
        chk("post_rst_short", int'(short), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
